linear_cordic_rotator: RTL and testbench

//  Iterative linear-mode CORDIC in ROTATION mode: computes y_out = y_in + x_in*z_in
//  by driving z to zero through the shared 2^-i angle-step table.

---
 rtl/linear_cordic_rotator_pkg.sv | 40 ++++
 rtl/linear_delta_rom.sv | 17 +
 rtl/linear_cordic_rotator.sv | 102 ++++++++++
 tb/tb_linear_cordic_rotator.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/linear_cordic_rotator_pkg.sv
// Shared constants, state encoding and output saturation for the linear CORDIC engines.
// Q2.14 signed operands; y accumulator carries guard bits above the data width.
package linear_cordic_rotator_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ITERATIONS = 16;
    localparam int GUARD_BITS = 2;
    localparam int ACC_WIDTH  = DATA_WIDTH + GUARD_BITS;
    localparam int ITER_WIDTH = 4;
    localparam int MAX_SHIFT  = 14;

    localparam logic [DATA_WIDTH-1:0] ONE     = 16'h4000;
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] y;
        logic                  ovf;
    } sat_t;

    // The value fits in DATA_WIDTH only when the guard bits and the data MSB all agree.
    function automatic sat_t saturate(input logic [ACC_WIDTH-1:0] acc);
        sat_t r;
        if (acc[ACC_WIDTH-1:DATA_WIDTH-1] == {(GUARD_BITS+1){acc[ACC_WIDTH-1]}}) begin
            r.y   = acc[DATA_WIDTH-1:0];
            r.ovf = 1'b0;
        end else begin
            r.y   = acc[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/linear_delta_rom.sv
// Linear-mode angle-step table: delta_z[i] = ONE >> i, with the final entry repeating 1 LSB.
// Purely combinational; shared with the vectoring datapath.
module linear_delta_rom
    import linear_cordic_rotator_pkg::*;
(
    input  logic [ITER_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] delta
);

    always_comb begin
        delta = ONE >> addr;
        if (addr == ITER_WIDTH'(ITERATIONS - 1)) begin
            delta = 16'h0001;
        end
    end

endmodule

// File: rtl/linear_cordic_rotator.sv
// Iterative linear rotation CORDIC: y_out = sat(y_in + x_in*z_in), one micro-rotation per cycle.
// Latency: accept cycle + 16 RUN cycles, result held in DONE until out_ready; new operands only in IDLE.
module linear_cordic_rotator
    import linear_cordic_rotator_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic [DATA_WIDTH-1:0] y_in,
    input  logic [DATA_WIDTH-1:0] z_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic [DATA_WIDTH-1:0] z_res,
    output logic                  ovf
);

    state_t                       state_q;
    state_t                       state_d;
    logic [ITER_WIDTH-1:0]        iter_q;
    logic [DATA_WIDTH-1:0]        x_q;
    logic [DATA_WIDTH-1:0]        z_q;
    logic signed [ACC_WIDTH-1:0]  y_acc_q;

    logic [DATA_WIDTH-1:0]        delta;
    logic [ITER_WIDTH-1:0]        shift;
    logic signed [ACC_WIDTH-1:0]  x_ext;
    logic signed [ACC_WIDTH-1:0]  x_shifted;
    logic signed [ACC_WIDTH-1:0]  y_next;
    logic [DATA_WIDTH-1:0]        z_next;
    logic                         dir_pos;
    logic                         last_iter;
    sat_t                         sat;

    linear_delta_rom u_delta_rom (
        .addr  (iter_q),
        .delta (delta)
    );

    // The last iteration reuses the 2^-14 shift so its step matches delta_z[15].
    assign shift     = (iter_q > ITER_WIDTH'(MAX_SHIFT)) ? ITER_WIDTH'(MAX_SHIFT) : iter_q;
    assign x_ext     = {{GUARD_BITS{x_q[DATA_WIDTH-1]}}, x_q};
    assign x_shifted = x_ext >>> shift;
    assign dir_pos   = ~z_q[DATA_WIDTH-1];
    assign y_next    = dir_pos ? (y_acc_q + x_shifted) : (y_acc_q - x_shifted);
    assign z_next    = dir_pos ? (z_q - delta) : (z_q + delta);
    assign last_iter = (iter_q == ITER_WIDTH'(ITERATIONS - 1));
    assign sat       = saturate(y_next);

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_iter) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            iter_q  <= '0;
            x_q     <= '0;
            z_q     <= '0;
            y_acc_q <= '0;
            y_out   <= '0;
            z_res   <= '0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q     <= x_in;
                        y_acc_q <= {{GUARD_BITS{y_in[DATA_WIDTH-1]}}, y_in};
                        z_q     <= z_in;
                        iter_q  <= '0;
                    end
                end
                ST_RUN: begin
                    y_acc_q <= y_next;
                    z_q     <= z_next;
                    iter_q  <= iter_q + ITER_WIDTH'(1);
                    // Output register loads straight from the final micro-rotation.
                    if (last_iter) begin
                        y_out <= sat.y;
                        ovf   <= sat.ovf;
                        z_res <= z_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_linear_cordic_rotator.sv
// Directed and randomised checks of the linear rotation CORDIC against hand values and a bit-level model.
module tb_linear_cordic_rotator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic [15:0] y_in;
    logic [15:0] z_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y_out;
    logic [15:0] z_res;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    linear_cordic_rotator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .z_res     (z_res),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic int sdiff(input logic [15:0] a, input logic [15:0] b);
        int d;
        d = int'($signed(a)) - int'($signed(b));
        return (d < 0) ? -d : d;
    endfunction

    task automatic ref_model(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                             output logic [15:0] ey, output logic [15:0] ez, output logic eovf);
        int acc;
        int sx;
        int s;
        logic signed [15:0] zz;
        logic [15:0] dz;
        sx  = int'($signed(x));
        acc = int'($signed(y));
        zz  = $signed(z);
        for (int i = 0; i < 16; i++) begin
            s  = (i > 14) ? 14 : i;
            dz = (i == 15) ? 16'h0001 : 16'(16'h4000 >> i);
            if (zz >= 0) begin
                acc = acc + (sx >>> s);
                zz  = zz - $signed(dz);
            end else begin
                acc = acc - (sx >>> s);
                zz  = zz + $signed(dz);
            end
        end
        eovf = 1'b0;
        if (acc > 32767) begin
            ey = 16'h7FFF; eovf = 1'b1;
        end else if (acc < -32768) begin
            ey = 16'h8000; eovf = 1'b1;
        end else begin
            ey = 16'(acc);
        end
        ez = zz;
    endtask

    // Drives one transaction with out_ready high; lat counts clock edges from the accepting edge.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                         output logic [15:0] ry, output logic [15:0] rz, output logic rovf,
                         output int lat);
        int n;
        ry = 'x; rz = 'x; rovf = 1'bx; lat = 0;
        @(negedge clk);
        x_in = x; y_in = y; z_in = z; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
        end
        total++;
        if (!out_valid) begin
            bad++;
            $display("FAIL result_timeout: out_valid=%b required 1", out_valid);
            return;
        end
        ry = y_out; rz = z_res; rovf = ovf;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x_in = '0; y_in = '0; z_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        total++;
        if ({in_ready, out_valid, y_out, z_res, ovf} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: rdy=%b vld=%b y=%h z=%h ovf=%b required 1 0 0000 0000 0",
                     in_ready, out_valid, y_out, z_res, ovf);
        end
    endtask

    task automatic test_basic();
        logic [15:0] ry, rz; logic rovf; int lat;
        do_op(16'h2000, 16'h0000, 16'h2000, ry, rz, rovf, lat);
        total++;
        if (lat !== 17) begin
            bad++; $display("FAIL basic_latency: got %0d cycles required 17", lat);
        end
        total++;
        if (sdiff(ry, 16'h1000) > 2 || rovf !== 1'b0) begin
            bad++; $display("FAIL basic_half_half: y=%h ovf=%b required 1000+/-2 ovf=0", ry, rovf);
        end
        do_op(16'h4000, 16'h1000, 16'hC000, ry, rz, rovf, lat);
        total++;
        if (sdiff(ry, 16'hD000) > 2 || rovf !== 1'b0) begin
            bad++; $display("FAIL basic_neg_mult: y=%h ovf=%b required D000+/-2 ovf=0", ry, rovf);
        end
        total++;
        if (sdiff(rz, 16'h0000) > 2) begin
            bad++; $display("FAIL basic_zres: z_res=%h required |z|<=2", rz);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] ry, rz; logic rovf; int lat;
        do_op(16'h7FFF, 16'h7FFF, 16'h7FFF, ry, rz, rovf, lat);
        total++;
        if (ry !== 16'h7FFF || rovf !== 1'b1) begin
            bad++; $display("FAIL sat_pos: y=%h ovf=%b required 7FFF 1", ry, rovf);
        end
        do_op(16'h8000, 16'h8000, 16'h7FFF, ry, rz, rovf, lat);
        total++;
        if (ry !== 16'h8000 || rovf !== 1'b1) begin
            bad++; $display("FAIL sat_neg: y=%h ovf=%b required 8000 1", ry, rovf);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] hy; logic hovf; int n;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        x_in = 16'h4000; y_in = 16'h0000; z_in = 16'h2000;
        @(posedge clk);
        #1 x_in = 16'h7FFF; y_in = 16'h7FFF; z_in = 16'h7FFF;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            #1;
        end
        total++;
        if (!out_valid) begin
            bad++; $display("FAIL bp_timeout: out_valid=%b required 1", out_valid);
        end
        hy = y_out; hovf = ovf;
        total++;
        if (sdiff(hy, 16'h2000) > 2 || hovf !== 1'b0) begin
            bad++; $display("FAIL bp_result: y=%h ovf=%b required 2000+/-2 ovf=0", hy, hovf);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (y_out !== hy || ovf !== hovf || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d y=%h ovf=%b vld=%b rdy=%b required %h %b 1 0",
                         c, y_out, ovf, out_valid, in_ready, hy, hovf);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_abort();
        logic [15:0] ry, rz; logic rovf; int lat; int seen;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        x_in = 16'h7FFF; y_in = 16'h1234; z_in = 16'h3000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        total++;
        if ({in_ready, out_valid, y_out, z_res, ovf} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
            bad++;
            $display("FAIL abort_state: rdy=%b vld=%b y=%h z=%h ovf=%b required 1 0 0000 0000 0",
                     in_ready, out_valid, y_out, z_res, ovf);
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL abort_no_emit: out_valid seen %0d cycles required 0", seen);
        end
        do_op(16'h4000, 16'h0000, 16'h2000, ry, rz, rovf, lat);
        total++;
        if (sdiff(ry, 16'h2000) > 2 || rovf !== 1'b0) begin
            bad++; $display("FAIL abort_recover: y=%h ovf=%b required 2000+/-2 ovf=0", ry, rovf);
        end
    endtask

    task automatic test_back_to_back();
        int t[3];
        int rises;
        logic prev;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        x_in = 16'h2000; y_in = 16'h0000; z_in = 16'h2000;
        rises = 0; prev = 1'b0;
        for (int c = 0; c < 100 && rises < 3; c++) begin
            @(posedge clk);
            #1;
            if (out_valid && !prev) begin
                t[rises] = c;
                rises++;
                total++;
                if (sdiff(y_out, 16'h1000) > 2) begin
                    bad++; $display("FAIL b2b_value: y=%h required 1000+/-2", y_out);
                end
            end
            prev = out_valid;
        end
        in_valid = 1'b0;
        total++;
        if (rises != 3) begin
            bad++; $display("FAIL b2b_count: results %0d required 3", rises);
        end else begin
            total++;
            if (t[1] - t[0] != 18 || t[2] - t[1] != 18) begin
                bad++;
                $display("FAIL b2b_period: gaps %0d %0d required 18 18", t[1] - t[0], t[2] - t[1]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [15:0] x, y, z, ry, rz, ey, ez; logic rovf, eovf; int lat;
        for (int k = 0; k < 100; k++) begin
            x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
            ref_model(x, y, z, ey, ez, eovf);
            do_op(x, y, z, ry, rz, rovf, lat);
            total++;
            if (sdiff(ry, ey) > 2 || rovf !== eovf) begin
                bad++;
                $display("FAIL rand_y: x=%h y=%h z=%h got %h ovf=%b required %h+/-2 ovf=%b",
                         x, y, z, ry, rovf, ey, eovf);
            end
            total++;
            if (rz !== ez || sdiff(rz, 16'h0000) > 2) begin
                bad++;
                $display("FAIL rand_zres: x=%h y=%h z=%h got %h required %h", x, y, z, rz, ez);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
